// File: rtl/riscbee_shift_pkg.sv
// riscbee_shift_pkg: shared widths, FSM states and fast-step size for iterative_shifter
package riscbee_shift_pkg;
  localparam int XLEN_DEF = 32;
  localparam int SHW_DEF = 5;
  localparam int STEP_FAST = 4;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/shift_step.sv
// shift_step: one combinational shift step (1 bit, or STEP_FAST bits when ITER_SHIFTER_FAST_EN and step4)
module shift_step
  import riscbee_shift_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] value,
  input  logic            dir,
  input  logic            fill,
`ifdef ITER_SHIFTER_FAST_EN
  input  logic            step4,
`endif
  output logic [XLEN-1:0] nxt
);
  logic [XLEN-1:0] one;
  assign one = dir ? {fill, value[XLEN-1:1]} : {value[XLEN-2:0], 1'b0};
`ifdef ITER_SHIFTER_FAST_EN
  logic [XLEN-1:0] four;
  assign four = dir ? {{STEP_FAST{fill}}, value[XLEN-1:STEP_FAST]} : {value[XLEN-1-STEP_FAST:0], {STEP_FAST{1'b0}}};
  assign nxt = step4 ? four : one;
`else
  assign nxt = one;
`endif
endmodule

// File: rtl/iterative_shifter.sv
// iterative_shifter: multi-cycle shifter (valid/ready in: A, shamt, arith, right; out: O; busy); ITER_SHIFTER_FAST_EN adds 4-bit steps
module iterative_shifter
  import riscbee_shift_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int SHW = SHW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] A,
  input  logic [SHW-1:0]  shamt,
  input  logic            arith,
  input  logic            right,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] O,
  output logic            busy
);
  state_t state, state_nxt;
  logic [XLEN-1:0] shreg, step_val;
  logic [SHW-1:0] count, count_nxt;
  logic fill, dir, accept;
`ifdef ITER_SHIFTER_FAST_EN
  logic step4;
  assign step4 = count >= SHW'(STEP_FAST);
  assign count_nxt = step4 ? count - SHW'(STEP_FAST) : count - SHW'(1);
  shift_step #(.XLEN(XLEN)) u_step (.value(shreg), .dir(dir), .fill(fill), .step4(step4), .nxt(step_val));
`else
  assign count_nxt = count - SHW'(1);
  shift_step #(.XLEN(XLEN)) u_step (.value(shreg), .dir(dir), .fill(fill), .nxt(step_val));
`endif
  always_comb begin
    req_ready = state == IDLE;
    resp_valid = state == DONE;
    busy = state != IDLE;
    accept = req_valid && req_ready;
    state_nxt = state == IDLE ? (accept ? (shamt == '0 ? DONE : SHIFT) : IDLE) :
                state == SHIFT ? (count_nxt == '0 ? DONE : SHIFT) :
                (resp_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      shreg <= '0;
      count <= '0;
      fill <= 1'b0;
      dir <= 1'b0;
      O <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        shreg <= A;
        count <= shamt;
        fill <= arith & right & A[XLEN-1];
        dir <= right;
        if (shamt == '0) O <= A;
      end else if (state == SHIFT) begin
        shreg <= step_val;
        count <= count_nxt;
        if (count_nxt == '0) O <= step_val;
      end
    end
  end
endmodule

// File: tb/tb_iterative_shifter.sv
// tb_iterative_shifter: directed checks of iterative_shifter results, latency, hold and reset
module tb_iterative_shifter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_ready, arith = 1'b0, right = 1'b0;
  logic resp_valid, resp_ready = 1'b0, busy;
  logic [31:0] A = '0, O;
  logic [4:0] shamt = '0;
  int errs = 0, checks = 0;
  iterative_shifter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .A(A), .shamt(shamt), .arith(arith), .right(right),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .O(O), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic int lat_of(input int s);
`ifdef ITER_SHIFTER_FAST_EN
    return s / 4 + s % 4 + 1;
`else
    return s + 1;
`endif
  endfunction
  task automatic run(input string tag, input logic [31:0] a, input logic [4:0] s, input logic ar,
                     input logic rt, input logic [31:0] exp, input int hold, input logic rr_early);
    int lat;
    @(negedge clk);
    A = a; shamt = s; arith = ar; right = rt; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0; A = ~a; shamt = ~s; arith = ~ar; right = ~rt; resp_ready = rr_early;
    lat = 1;
    while (!resp_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    check({tag, "_lat"}, lat, lat_of(int'(s)));
    check({tag, "_O"}, O, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1 check({tag, "_holdO"}, O, exp);
      check({tag, "_hold_rdy"}, {31'b0, req_ready}, 0);
      check({tag, "_hold_busy"}, {31'b0, busy}, 1);
      check({tag, "_hold_vld"}, {31'b0, resp_valid}, 1);
    end
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    check({tag, "_drop"}, {31'b0, resp_valid}, 0);
    check({tag, "_idleO"}, O, exp);
    check({tag, "_rdy"}, {31'b0, req_ready}, 1);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 check("rst_O", O, 0);
    check("rst_vld", {31'b0, resp_valid}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst_rdy", {31'b0, req_ready}, 1);
    run("srl3", 32'h0000_0116, 5'd3, 1'b0, 1'b1, 32'h0000_0022, 0, 1'b0);
    run("sra4", 32'h8000_0000, 5'd4, 1'b1, 1'b1, 32'hF800_0000, 0, 1'b0);
    run("srl4", 32'h8000_0000, 5'd4, 1'b0, 1'b1, 32'h0800_0000, 0, 1'b0);
    run("sll31", 32'h0000_0001, 5'd31, 1'b0, 1'b0, 32'h8000_0000, 0, 1'b1);
    run("sh0", 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 32'hDEAD_BEEF, 5, 1'b0);
    run("sll20", 32'h1234_5678, 5'd20, 1'b0, 1'b0, 32'h6780_0000, 0, 1'b0);
    run("arl1", 32'h8000_0001, 5'd1, 1'b1, 1'b0, 32'h0000_0002, 0, 1'b0);
    run("sra5p", 32'h7FFF_FFF0, 5'd5, 1'b1, 1'b1, 32'h03FF_FFFF, 0, 1'b0);
    run("sra31", 32'h8000_0000, 5'd31, 1'b1, 1'b1, 32'hFFFF_FFFF, 0, 1'b0);
    run("sll5", 32'h0000_0003, 5'd5, 1'b0, 1'b0, 32'h0000_0060, 0, 1'b0);
    @(negedge clk);
    A = 32'h0000_0001; shamt = 5'd31; arith = 1'b0; right = 1'b0; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("mid_busy", {31'b0, busy}, 1);
    rst_n = 1'b0;
    #1 check("mid_O", O, 0);
    check("mid_vld", {31'b0, resp_valid}, 0);
    check("mid_busy0", {31'b0, busy}, 0);
    check("mid_rdy", {31'b0, req_ready}, 1);
    @(negedge clk);
    rst_n = 1'b1;
    run("post_rst", 32'h0000_00F0, 5'd4, 1'b0, 1'b1, 32'h0000_000F, 0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
